// File: rtl/muldiv_ctrl.sv
// Sequencer for the multi-cycle HI/LO unit: fixed-latency multiply, WIDTH-step restoring divide,
// pipeline stall while busy and a single-cycle HI/LO write pulse.
module muldiv_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CNT_W = $clog2((WIDTH > MUL_LAT) ? WIDTH : MUL_LAT) + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;       // raw multiplier, or divisor magnitude
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;   // dividend magnitude shifting out, quotient shifting in
    logic               sgn_q, sgn_d;
    logic               bneg_q, bneg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               accept;
    logic               in_signed;
    logic [WIDTH-1:0]   a_mag_in;
    logic [WIDTH-1:0]   b_mag_in;
    logic [PW-1:0]      ext_a;
    logic [PW-1:0]      ext_b;
    logic [PW-1:0]      prod;
    logic [WIDTH:0]     rem_sh;
    logic               ge;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic               a_neg;

    assign accept    = start_i & ~cancel_i;
    assign in_signed = ~op_i[0];
    assign a_mag_in  = (in_signed & a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag_in  = (in_signed & b_i[WIDTH-1]) ? -b_i : b_i;

    // Sign/zero extension to 2W makes the truncated product correct for both MULT and MULTU
    assign ext_a = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
    assign ext_b = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
    assign prod  = ext_a * ext_b;

    // One restoring step: shift in the next dividend bit, subtract divisor if it fits
    assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
    assign ge       = rem_sh >= {1'b0, b_q};
    assign rem_step = ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], ge};
    assign a_neg    = sgn_q & a_q[WIDTH-1];

    assign stall_o = ((state_q == S_IDLE) & accept) | (state_q == S_MUL) | (state_q == S_DIV);
    assign done_o  = done_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        sgn_d   = sgn_q;
        bneg_d  = bneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d   = a_i;
                    sgn_d = in_signed;
                    cnt_d = '0;
                    if (!op_i[1]) begin
                        b_d     = b_i;
                        state_d = S_MUL;
                    end else if (b_i == '0) begin
                        hi_d    = a_i;
                        lo_d    = '1;
                        state_d = S_DONE;
                    end else begin
                        b_d     = b_mag_in;
                        bneg_d  = in_signed & b_i[WIDTH-1];
                        rem_d   = '0;
                        quo_d   = a_mag_in;
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
                    hi_d    = prod[PW-1:WIDTH];
                    lo_d    = prod[WIDTH-1:0];
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DIV: begin
                if (cancel_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        lo_d    = (a_neg ^ bneg_q) ? -quo_step : quo_step;
                        hi_d    = a_neg ? -rem_step : rem_step;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            sgn_q   <= 1'b0;
            bneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            sgn_q   <= sgn_d;
            bneg_q  <= bneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, stall window, signed/unsigned results, cancel and reset.
module tb_muldiv_ctrl;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [1:0]   op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cancel_i;
    logic         stall_o;
    logic         done_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int tests = 0;
    int fails = 0;

    muldiv_ctrl #(.WIDTH(32), .MUL_LAT(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cancel_i(cancel_i),
        .stall_o (stall_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    // Issue one op in the next cycle (cycle 0) and follow it until done_o or a 60-cycle budget
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int stalls,
                          output logic [W-1:0] hi, output logic [W-1:0] lo);
        lat    = -1;
        stalls = 0;
        hi     = '0;
        lo     = '0;
        @(posedge clk); #1;
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (stall_o) stalls++;
            if (done_o) begin
                lat = c;
                hi  = hi_o;
                lo  = lo_o;
                break;
            end
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; cancel_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({done_o, stall_o, hi_o, lo_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got done=%b stall=%b hi=%h lo=%h want all zero",
                     done_o, stall_o, hi_o, lo_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_mult();
        int lat, st;
        logic [W-1:0] hi, lo;
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, lat, st, hi, lo);
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL mult_latency got %0d want 3", lat); end
        tests++;
        if (st !== 3) begin fails++; $display("FAIL mult_stall_cycles got %0d want 3", st); end
        tests++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
            fails++; $display("FAIL mult_signed got %h_%h want FFFFFFFF_FFFFFFF1", hi, lo);
        end
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, st, hi, lo);
        tests++;
        if (lat !== 3) begin fails++; $display("FAIL multu_latency got %0d want 3", lat); end
        tests++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
            fails++; $display("FAIL multu_max got %h_%h want FFFFFFFE_00000001", hi, lo);
        end
    endtask

    task automatic test_divide();
        int lat, st;
        logic [W-1:0] hi, lo;
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat, st, hi, lo);
        tests++;
        if (lat !== 33) begin fails++; $display("FAIL div_latency got %0d want 33", lat); end
        tests++;
        if (st !== 33) begin fails++; $display("FAIL div_stall_cycles got %0d want 33", st); end
        tests++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            fails++; $display("FAIL div_neg7_2 got hi=%h lo=%h want FFFFFFFF FFFFFFFD", hi, lo);
        end
        run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, lat, st, hi, lo);
        tests++;
        if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) begin
            fails++; $display("FAIL div_7_neg2 got hi=%h lo=%h want 00000001 FFFFFFFD", hi, lo);
        end
        run_op(2'b11, 32'd100, 32'd7, lat, st, hi, lo);
        tests++;
        if ({hi, lo} !== 64'h0000_0002_0000_000E) begin
            fails++; $display("FAIL divu_100_7 got hi=%h lo=%h want 00000002 0000000E", hi, lo);
        end
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, st, hi, lo);
        tests++;
        if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
            fails++; $display("FAIL div_overflow got hi=%h lo=%h want 00000000 80000000", hi, lo);
        end
        run_op(2'b11, 32'h0000_1234, 32'h0, lat, st, hi, lo);
        tests++;
        if (lat !== 1) begin fails++; $display("FAIL div0_latency got %0d want 1", lat); end
        tests++;
        if ({hi, lo} !== 64'h0000_1234_FFFF_FFFF) begin
            fails++; $display("FAIL div0_result got hi=%h lo=%h want 00001234 FFFFFFFF", hi, lo);
        end
    endtask

    // Follows test_divide: HI/LO must still hold the divide-by-zero result
    task automatic test_cancel();
        int lat, st;
        logic [W-1:0] hi, lo;
        int early_done = 0;
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 2'b10; a_i = 32'd100; b_i = 32'd7;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (done_o) early_done++;
            @(posedge clk); #1;
            start_i  = 1'b0;
            cancel_i = (c == 9);
        end
        cancel_i = 1'b0;
        @(negedge clk);
        tests++;
        if (early_done !== 0 || done_o !== 1'b0) begin
            fails++; $display("FAIL cancel_no_done got %0d pulses want 0", early_done + int'(done_o));
        end
        tests++;
        if (stall_o !== 1'b0) begin fails++; $display("FAIL cancel_stall got %b want 0", stall_o); end
        tests++;
        if ({hi_o, lo_o} !== 64'h0000_1234_FFFF_FFFF) begin
            fails++; $display("FAIL cancel_hold got hi=%h lo=%h want 00001234 FFFFFFFF", hi_o, lo_o);
        end
        run_op(2'b01, 32'd6, 32'd7, lat, st, hi, lo);
        tests++;
        if (lat !== 3 || {hi, lo} !== 64'd42) begin
            fails++; $display("FAIL after_cancel got lat=%0d %h_%h want 3 0_2A", lat, hi, lo);
        end

        // cancel beats start in IDLE
        @(posedge clk); #1;
        start_i = 1'b1; cancel_i = 1'b1; op_i = 2'b00; a_i = 32'd9; b_i = 32'd9;
        @(negedge clk);
        tests++;
        if (stall_o !== 1'b0) begin fails++; $display("FAIL cancel_beats_start stall got %b want 0", stall_o); end
        @(posedge clk); #1;
        start_i = 1'b0; cancel_i = 1'b0;
        early_done = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done_o || stall_o) early_done++;
        end
        tests++;
        if (early_done !== 0 || lo_o !== 32'd42) begin
            fails++; $display("FAIL cancel_beats_start_idle got busy=%0d lo=%h want 0 0000002A", early_done, lo_o);
        end

        // cancel in the DONE cycle still writes
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 2'b00; a_i = 32'd3; b_i = 32'd4;
        @(posedge clk); #1; start_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; cancel_i = 1'b1;
        @(negedge clk);
        tests++;
        if (done_o !== 1'b1 || lo_o !== 32'd12) begin
            fails++; $display("FAIL cancel_in_done got done=%b lo=%h want 1 0000000C", done_o, lo_o);
        end
        @(posedge clk); #1; cancel_i = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int late_done = 0;
        @(posedge clk); #1;
        start_i = 1'b1; op_i = 2'b11; a_i = 32'd1000; b_i = 32'd3;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({done_o, stall_o, hi_o, lo_o} !== '0) begin
            fails++; $display("FAIL reset_mid_div got done=%b stall=%b hi=%h lo=%h want all zero",
                              done_o, stall_o, hi_o, lo_o);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_o || stall_o) late_done++;
        end
        tests++;
        if (late_done !== 0) begin fails++; $display("FAIL reset_mid_div_idle got %0d busy cycles want 0", late_done); end
    endtask

    task automatic test_back_to_back();
        int lat, st;
        logic [W-1:0] hi, lo;
        run_op(2'b00, 32'h0001_0000, 32'h0001_0000, lat, st, hi, lo);
        tests++;
        if (lat !== 3 || {hi, lo} !== 64'h0000_0001_0000_0000) begin
            fails++; $display("FAIL b2b_mult got lat=%0d %h_%h want 3 00000001_00000000", lat, hi, lo);
        end
        run_op(2'b10, 32'hFFFF_FF9C, 32'd9, lat, st, hi, lo);
        tests++;
        if (lat !== 33 || {hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF5) begin
            fails++; $display("FAIL b2b_div got lat=%0d hi=%h lo=%h want 33 FFFFFFFF FFFFFFF5", lat, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divide();
        test_cancel();
        test_reset_mid_op();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
